tdm_linear_layer: RTL and testbench

Time-multiplexed successor to the combinational-per-cycle linear layer. It computes y = W·x + b in signed fixed point using LANES parallel MAC lanes. Each lane does one multiply-accumulate per clock, so the block spans IN_SIZE*OUT_SIZE/LANES cycles instead of IN_SIZE*OUT_SIZE multipliers. It sits between layers of the SoH predictor network, has valid/ready handshakes on both sides, saturates its outputs, and can optionally fuse ReLU.

---
 rtl/nn_fixed_pkg.sv | 54 +++++
 rtl/tdm_linear_layer_mac_lane.sv | 47 ++++
 rtl/tdm_linear_layer.sv | 122 ++++++++++++
 tb/tb_tdm_linear_layer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_fixed_pkg.sv
// Shared fixed-point helpers for the SoH predictor layers: defaults, FSM states,
// saturation and flattened-bus element indexing.
package nn_fixed_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned FRAC_W_DEF = 16;
    localparam int unsigned SAT_DATA_W = 64;
    localparam int unsigned SAT_ACC_W  = 160;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } state_e;

    // Clamp a wide signed accumulator into a data_w-bit signed range.
    function automatic logic [SAT_DATA_W-1:0] sat_to_data(
        input logic signed [SAT_ACC_W-1:0] acc,
        input int unsigned                 data_w
    );
        logic signed [SAT_ACC_W-1:0] hi;
        logic signed [SAT_ACC_W-1:0] lo;
        hi = (SAT_ACC_W'(1) <<< (data_w - 1)) - SAT_ACC_W'(1);
        lo = ~hi;
        if (acc > hi) begin
            return SAT_DATA_W'(hi);
        end
        if (acc < lo) begin
            return SAT_DATA_W'(lo);
        end
        return SAT_DATA_W'(acc);
    endfunction

    // LSB of element idx in a bus where element 0 sits in the top slot.
    function automatic int unsigned elem_lsb(
        input int unsigned idx,
        input int unsigned count,
        input int unsigned w
    );
        return (count - idx - 1) * w;
    endfunction

    // LSB of W[row][col] in the row-major flattened weight bus.
    function automatic int unsigned mat_lsb(
        input int unsigned row,
        input int unsigned col,
        input int unsigned cols,
        input int unsigned rows,
        input int unsigned w
    );
        return (cols * rows - row * cols - col - 1) * w;
    endfunction

endpackage

// File: rtl/tdm_linear_layer_mac_lane.sv
// One multiply-shift-accumulate lane with bias load and saturating writeback.
// Optional fused ReLU on writeback when TDM_LINEAR_FUSED_RELU_EN is defined.
module mac_lane
    import nn_fixed_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned FRAC_W = FRAC_W_DEF,
    parameter int unsigned ACC_W  = 2 * DATA_W_DEF - FRAC_W_DEF + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              step,
    input  logic              first,
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] w,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] wb_data_c
);

    logic signed [2*DATA_W-1:0] prod_c;
    logic signed [2*DATA_W-1:0] term_c;
    logic signed [ACC_W-1:0]    acc;
    logic signed [ACC_W-1:0]    acc_next_c;
    logic        [DATA_W-1:0]   sat_c;

    // The shifted term keeps FRAC_W redundant sign bits, so narrowing to ACC_W is lossless.
    always_comb begin
        prod_c     = (2*DATA_W)'($signed(x)) * (2*DATA_W)'($signed(w));
        term_c     = prod_c >>> FRAC_W;
        acc_next_c = (first ? ACC_W'($signed(b)) : acc) + ACC_W'(term_c);
        sat_c      = DATA_W'(sat_to_data(SAT_ACC_W'(acc_next_c), DATA_W));
`ifdef TDM_LINEAR_FUSED_RELU_EN
        wb_data_c  = sat_c[DATA_W-1] ? '0 : sat_c;
`else
        wb_data_c  = sat_c;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc <= '0;
        end else if (step) begin
            acc <= acc_next_c;
        end
    end

endmodule

// File: rtl/tdm_linear_layer.sv
// Time-multiplexed y = W*x + b with LANES MAC lanes and valid/ready on both sides.
// Define TDM_LINEAR_FUSED_RELU_EN to clamp negative outputs to zero at writeback.
module tdm_linear_layer
    import nn_fixed_pkg::*;
#(
    parameter int unsigned IN_SIZE  = 4,
    parameter int unsigned OUT_SIZE = 64,
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned FRAC_W   = FRAC_W_DEF,
    parameter int unsigned LANES    = 1
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [IN_SIZE*DATA_W-1:0]           in_data,
    input  logic [OUT_SIZE*IN_SIZE*DATA_W-1:0]  weights,
    input  logic [OUT_SIZE*DATA_W-1:0]          biases,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [OUT_SIZE*DATA_W-1:0]          out_data,
    output logic                                busy
);

    localparam int unsigned GROUPS = OUT_SIZE / LANES;
    localparam int unsigned J_W    = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;
    localparam int unsigned G_W    = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int unsigned ACC_W  = 2 * DATA_W - FRAC_W + $clog2(IN_SIZE) + 1;

    if (OUT_SIZE % LANES != 0) begin : g_bad_lanes
        $error("tdm_linear_layer: LANES must divide OUT_SIZE");
    end

    state_e                    state;
    state_e                    state_next;
    logic [J_W-1:0]            j;
    logic [G_W-1:0]            g;
    logic [IN_SIZE*DATA_W-1:0] x_reg;
    logic                      accept_c;
    logic                      j_last_c;
    logic                      g_last_c;
    logic                      step_c;
    logic [DATA_W-1:0]         x_j_c;
    logic [LANES*DATA_W-1:0]   lane_wb_c;

    assign accept_c = in_valid && in_ready;
    assign step_c   = (state == COMPUTE);
    assign j_last_c = (j == J_W'(IN_SIZE - 1));
    assign g_last_c = (g == G_W'(GROUPS - 1));
    assign x_j_c    = x_reg[elem_lsb(32'(j), IN_SIZE, DATA_W) +: DATA_W];

    // Lane l of group g serves neuron g*LANES+l; weights and biases are read live.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [31:0] n_c;
        assign n_c = 32'(g) * LANES + 32'(l);

        mac_lane #(
            .DATA_W (DATA_W),
            .FRAC_W (FRAC_W),
            .ACC_W  (ACC_W)
        ) u_lane (
            .clk       (clk),
            .reset     (reset),
            .step      (step_c),
            .first     (j == '0),
            .x         (x_j_c),
            .w         (weights[mat_lsb(n_c, 32'(j), IN_SIZE, OUT_SIZE, DATA_W) +: DATA_W]),
            .b         (biases[elem_lsb(n_c, OUT_SIZE, DATA_W) +: DATA_W]),
            .wb_data_c (lane_wb_c[l*DATA_W +: DATA_W])
        );
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept_c) state_next = COMPUTE;
            COMPUTE: if (j_last_c && g_last_c) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake flags are registered copies of the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_next;
            in_ready  <= (state_next == IDLE);
            busy      <= (state_next == COMPUTE);
            out_valid <= (state_next == DONE);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_reg    <= '0;
            j        <= '0;
            g        <= '0;
            out_data <= '0;
        end else if (accept_c) begin
            x_reg <= in_data;
            j     <= '0;
            g     <= '0;
        end else if (step_c) begin
            if (j_last_c) begin
                j <= '0;
                g <= g_last_c ? '0 : g + G_W'(1);
                for (int unsigned l = 0; l < LANES; l++) begin
                    out_data[elem_lsb(32'(g) * LANES + l, OUT_SIZE, DATA_W) +: DATA_W]
                        <= lane_wb_c[l*DATA_W +: DATA_W];
                end
            end else begin
                j <= j + J_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_tdm_linear_layer.sv
// Bench for tdm_linear_layer: two instances (LANES=2 and LANES=4) on shared stimulus,
// compared every cycle against a plain-arithmetic floor-rounding model.
module tb_tdm_linear_layer;

    localparam int unsigned IN_SIZE  = 4;
    localparam int unsigned OUT_SIZE = 4;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned FRAC_W   = 16;
    localparam int unsigned N2       = 8;
    localparam int unsigned N4       = 4;
    localparam int          TIMEOUT  = 40;
    localparam longint      SAT_HI   = 64'sh0000_0000_7FFF_FFFF;
    localparam longint      SAT_LO   = -64'sh0000_0000_8000_0000;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         out_ready;
    logic [127:0] in_data;
    logic [511:0] weights;
    logic [127:0] biases;
    logic         in_ready2, out_valid2, busy2;
    logic         in_ready4, out_valid4, busy4;
    logic [127:0] out_data2, out_data4;

    int           x_arr [4];
    int           w_arr [4][4];
    int           b_arr [4];
    logic [127:0] exp_bus;
    logic [127:0] lit;
    int           total;
    int           bad;
    int           cnt2, cnt4;
    bit           armed2, armed4;

    tdm_linear_layer #(
        .IN_SIZE(IN_SIZE), .OUT_SIZE(OUT_SIZE), .DATA_W(DATA_W), .FRAC_W(FRAC_W), .LANES(2)
    ) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
        .in_data(in_data), .weights(weights), .biases(biases),
        .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2), .busy(busy2)
    );

    tdm_linear_layer #(
        .IN_SIZE(IN_SIZE), .OUT_SIZE(OUT_SIZE), .DATA_W(DATA_W), .FRAC_W(FRAC_W), .LANES(4)
    ) dut4 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready4),
        .in_data(in_data), .weights(weights), .biases(biases),
        .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4), .busy(busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
        end
    endtask

    // y[i] = sat(b[i] + sum_j floor(x[j]*W[i][j] / 2^FRAC_W))
    function automatic int model_y(input int i);
        longint acc;
        acc = longint'(b_arr[i]);
        for (int k = 0; k < 4; k++) begin
            acc += (longint'(x_arr[k]) * longint'(w_arr[i][k])) >>> FRAC_W;
        end
        if (acc > SAT_HI) acc = SAT_HI;
        else if (acc < SAT_LO) acc = SAT_LO;
`ifdef TDM_LINEAR_FUSED_RELU_EN
        if (acc < 0) acc = 0;
`endif
        return int'(acc);
    endfunction

    task automatic set_exp();
        for (int i = 0; i < 4; i++) exp_bus[(3-i)*32 +: 32] = model_y(i);
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            in_data[(3-i)*32 +: 32] = x_arr[i];
            biases[(3-i)*32 +: 32]  = b_arr[i];
            for (int k = 0; k < 4; k++) weights[(15-i*4-k)*32 +: 32] = w_arr[i][k];
        end
    endtask

    function automatic int rnd_val();
        int v;
        case ($urandom_range(0, 3))
            0:       v = int'($urandom);
            1:       v = int'($urandom_range(0, 32'h000A_0000)) - 32'sh0005_0000;
            default: v = int'($urandom_range(0, 32'h0004_0000)) - 32'sh0002_0000;
        endcase
        return v;
    endfunction

    task automatic rand_vec();
        for (int i = 0; i < 4; i++) begin
            x_arr[i] = rnd_val();
            b_arr[i] = rnd_val();
            for (int k = 0; k < 4; k++) w_arr[i][k] = rnd_val();
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (!(out_valid2 && out_valid4) && t < TIMEOUT) begin
            tick();
            t++;
        end
        check("done_in_time", 128'({out_valid2, out_valid4}), 128'(2'b11));
    endtask

    task automatic run_vec();
        drive();
        set_exp();
        check("ready_before_accept", 128'({in_ready2, in_ready4}), 128'(2'b11));
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_data  = {$urandom, $urandom, $urandom, $urandom};
        wait_done();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    // Cycles since accept, counted on the edges the DUT sees.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            armed2 <= 1'b0; armed4 <= 1'b0; cnt2 <= 0; cnt4 <= 0;
        end else begin
            if (in_valid && in_ready2) begin armed2 <= 1'b1; cnt2 <= 0; end
            else if (armed2 && out_valid2) armed2 <= 1'b0;
            else if (armed2) cnt2 <= cnt2 + 1;
            if (in_valid && in_ready4) begin armed4 <= 1'b1; cnt4 <= 0; end
            else if (armed4 && out_valid4) armed4 <= 1'b0;
            else if (armed4) cnt4 <= cnt4 + 1;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid2) begin
                check("y_lanes2", out_data2, exp_bus);
                check("hs_done_lanes2", 128'({in_ready2, busy2}), 128'(2'b00));
                if (armed2) check("latency_lanes2", 128'(cnt2), 128'(N2));
            end else if (armed2) begin
                check("hs_compute_lanes2", 128'({in_ready2, busy2}), 128'(2'b01));
            end
            if (out_valid4) begin
                check("y_lanes4", out_data4, exp_bus);
                check("hs_done_lanes4", 128'({in_ready4, busy4}), 128'(2'b00));
                if (armed4) check("latency_lanes4", 128'(cnt4), 128'(N4));
            end else if (armed4) begin
                check("hs_compute_lanes4", 128'({in_ready4, busy4}), 128'(2'b01));
            end
        end
    end

    initial begin
        total = 0; bad = 0;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; weights = '0; biases = '0; exp_bus = '0;
        #7;
        check("rst_ctrl", 128'({out_valid2, out_valid4, in_ready2, in_ready4, busy2, busy4}),
              128'(6'b001100));
        check("rst_data2", out_data2, 128'(0));
        check("rst_data4", out_data4, 128'(0));
        @(negedge clk);
        #1 reset = 1'b0;

        // identity
        x_arr = '{32'h0001_0000, 32'h0002_0000, 32'hFFFD_0000, 32'h0000_8000};
        for (int i = 0; i < 4; i++) begin
            b_arr[i] = 0;
            for (int k = 0; k < 4; k++) w_arr[i][k] = (i == k) ? 32'h0001_0000 : 0;
        end
        set_exp();
`ifdef TDM_LINEAR_FUSED_RELU_EN
        lit = {32'h0001_0000, 32'h0002_0000, 32'h0000_0000, 32'h0000_8000};
`else
        lit = {32'h0001_0000, 32'h0002_0000, 32'hFFFD_0000, 32'h0000_8000};
`endif
        check("model_identity", exp_bus, lit);
        run_vec();

        // bias plus accumulate
        for (int i = 0; i < 4; i++) begin
            b_arr[i] = i * 32'h0001_0000;
            for (int k = 0; k < 4; k++) w_arr[i][k] = 32'h0000_8000;
        end
        set_exp();
        lit = {32'h0000_4000, 32'h0001_4000, 32'h0002_4000, 32'h0003_4000};
        check("model_bias", exp_bus, lit);
        run_vec();

        // positive and negative saturation
        for (int i = 0; i < 4; i++) begin
            x_arr[i] = 32'h7FFF_0000;
            b_arr[i] = 0;
            for (int k = 0; k < 4; k++) w_arr[i][k] = 32'h7FFF_0000;
        end
        set_exp();
        lit = {4{32'h7FFF_FFFF}};
        check("model_sat_hi", exp_bus, lit);
        run_vec();
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++) w_arr[i][k] = 32'h8001_0000;
        set_exp();
`ifdef TDM_LINEAR_FUSED_RELU_EN
        lit = '0;
`else
        lit = {4{32'h8000_0000}};
`endif
        check("model_sat_lo", exp_bus, lit);
        run_vec();

        // backpressure with an ignored in_valid pulse
        rand_vec();
        drive();
        set_exp();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_done();
        for (int c = 0; c < 10; c++) begin
            in_valid = (c == 4);
            if (c == 4) in_data = {$urandom, $urandom, $urandom, $urandom};
            tick();
            check("bp_hold", 128'({out_valid2, out_valid4, in_ready2, in_ready4}), 128'(4'b1100));
        end
        for (int i = 0; i < 4; i++) x_arr[i] = rnd_val();
        drive();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        tick();
        out_ready = 1'b0;
        set_exp();
        check("bp_idle_after_hs",
              128'({out_valid2, out_valid4, in_ready2, in_ready4, busy2, busy4}), 128'(6'b001100));
        tick();
        in_valid = 1'b0;
        check("bp_accept_next", 128'({in_ready2, in_ready4, busy2, busy4}), 128'(4'b0011));
        wait_done();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // reset three cycles into COMPUTE
        rand_vec();
        drive();
        set_exp();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        reset = 1'b1;
        #1;
        check("rst_mid_ctrl",
              128'({out_valid2, out_valid4, in_ready2, in_ready4, busy2, busy4}), 128'(6'b001100));
        check("rst_mid_data2", out_data2, 128'(0));
        check("rst_mid_data4", out_data4, 128'(0));
        @(negedge clk);
        #1 reset = 1'b0;
        rand_vec();
        run_vec();

        // random vectors
        for (int v = 0; v < 1000; v++) begin
            rand_vec();
            run_vec();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
